// File: rtl/arp_pkg.sv
// Shared ARP constants, state encoding and field packing for the encoder/decoder pair.
package arp_pkg;

    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN       = 8'd6;
    localparam logic [7:0]  ARP_PLEN       = 8'd4;
    localparam logic [15:0] ARP_OPER_REQ   = 16'd1;
    localparam logic [15:0] ARP_OPER_REP   = 16'd2;
    localparam int          ARP_LEN        = 28;
    localparam int          ARP_BITS       = ARP_LEN * 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_PAD  = 2'd2
    } arp_state_e;

    // Assemble the 28-byte payload, byte 0 in the top bits. Requests carry a zero THA.
    function automatic logic [ARP_BITS-1:0] arp_pack(
        input logic        oper_reply,
        input logic [47:0] sha,
        input logic [31:0] spa,
        input logic [47:0] tha,
        input logic [31:0] tpa
    );
        logic [15:0] oper;
        logic [47:0] tha_eff;
        oper    = oper_reply ? ARP_OPER_REP : ARP_OPER_REQ;
        tha_eff = oper_reply ? tha : 48'h0;
        return {ARP_HTYPE_ETH, ARP_PTYPE_IPV4, ARP_HLEN, ARP_PLEN,
                oper, sha, spa, tha_eff, tpa};
    endfunction

endpackage

// File: rtl/arp_encode.sv
// Byte-serial ARP payload generator: captures address fields on start and streams
// the packet MSB-first over a valid/ready byte interface, optionally zero-padded.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | no packet in flight; start captures fields
// SEND    | emitting ARP field bytes 0..27 from the shift register
// PAD     | emitting 0x00 bytes 28..PAD_LEN-1 (only when PAD_LEN > 28)
import arp_pkg::*;

module arp_encode #(
    parameter int PAD_LEN = 28
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        oper_reply,
    input  logic [47:0] our_mac,
    input  logic [31:0] our_ip,
    input  logic [47:0] tgt_mac,
    input  logic [31:0] tgt_ip,
    output logic [7:0]  dout,
    output logic        dout_valid,
    input  logic        dout_ready,
    output logic        dout_last,
    output logic        busy,
    output logic        done
);

    localparam logic [7:0] LAST_IDX   = 8'(PAD_LEN - 1);
    localparam logic [7:0] FIELD_LAST = 8'(ARP_LEN - 1);
    localparam bit         HAS_PAD    = (PAD_LEN > ARP_LEN);

    arp_state_e          state_q, state_d;
    logic [7:0]          idx_q;
    logic [ARP_BITS-1:0] sreg_q;
    logic                done_q;

    logic hs;
    logic load;
    logic shift;
    logic idx_clr;
    logic idx_inc;
    logic done_d;

    assign hs = dout_valid & dout_ready;

    // State register; reset aborts any packet in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath control. Index stops at the last byte instead of wrapping.
    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        shift   = 1'b0;
        idx_clr = 1'b0;
        idx_inc = 1'b0;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_SEND;
                    load    = 1'b1;
                    idx_clr = 1'b1;
                end
            end
            ST_SEND: begin
                if (hs) begin
                    shift = 1'b1;
                    if (idx_q == FIELD_LAST) begin
                        if (HAS_PAD) begin
                            state_d = ST_PAD;
                            idx_inc = 1'b1;
                        end else begin
                            state_d = ST_IDLE;
                            done_d  = 1'b1;
                            idx_clr = 1'b1;
                        end
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            ST_PAD: begin
                if (hs) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_IDLE;
                        done_d  = 1'b1;
                        idx_clr = 1'b1;
                    end else begin
                        idx_inc = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Capture register, byte index and done pulse. Shifting zero-fills, so the register
    // is already clear when the packet completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sreg_q <= '0;
            idx_q  <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= done_d;
            if (load) begin
                sreg_q <= arp_pack(oper_reply, our_mac, our_ip, tgt_mac, tgt_ip);
            end else if (shift) begin
                sreg_q <= {sreg_q[ARP_BITS-9:0], 8'h00};
            end
            if (idx_clr) begin
                idx_q <= '0;
            end else if (idx_inc) begin
                idx_q <= idx_q + 8'd1;
            end
        end
    end

    // Outputs derive from registered state only, so they hold stable while stalled.
    always_comb begin
        dout_valid = (state_q != ST_IDLE);
        busy       = (state_q != ST_IDLE);
        dout       = (state_q == ST_SEND) ? sreg_q[ARP_BITS-1 -: 8] : 8'h00;
        dout_last  = dout_valid && (idx_q == LAST_IDX);
        done       = done_q;
    end

endmodule

// File: doc/arp_encode.md
Name: arp_encode

Overview:
- Byte-serial ARP packet generator on the transmit side of the Ethernet path.
- Builds a 28-byte ARP payload (request or reply) from captured address fields and streams it MSB-first to the MAC transmit framer over a valid/ready byte interface.
- Optionally zero-pads the payload to the minimum Ethernet payload length.
- Pairs with the receive-side ARP decoder: decoded sha/spa feed tgt_mac/tgt_ip here to answer a request.

Parameters:
- PAD_LEN, 28, total bytes emitted per packet. Legal range 28..255; bytes 28..PAD_LEN-1 are 0x00. Use 46 for minimum Ethernet payload.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle request to send; sampled only in IDLE
- oper_reply  input  1  0 = ARP request (OPER 1), 1 = ARP reply (OPER 2); captured on start
- our_mac  input  48  sender hardware address (SHA); captured on start
- our_ip  input  32  sender protocol address (SPA); captured on start
- tgt_mac  input  48  target hardware address (THA); captured on start, forced to 0 for requests
- tgt_ip  input  32  target protocol address (TPA); captured on start
- dout  output  8  payload byte
- dout_valid  output  1  dout holds a valid byte
- dout_ready  input  1  downstream accepts the byte this cycle
- dout_last  output  1  high with the final byte (index PAD_LEN-1)
- busy  output  1  high from the cycle after start acceptance until the final handshake
- done  output  1  one-cycle pulse the cycle after the final byte handshake

Behaviour:
- Reset (async assert, sync release):
  - dout=0, dout_valid=0, dout_last=0, busy=0, done=0.
  - Byte index=0, state=IDLE, capture register cleared.
- States: IDLE -> SEND -> (PAD if PAD_LEN>28) -> IDLE.
- IDLE:
  - dout_valid=0.
  - start=1 captures all fields into a 224-bit shift register and moves to SEND.
  - Next cycle: busy=1, dout_valid=1, dout=byte 0.
- Byte layout (big-endian), by index:
  - 0-1: 0x0001 (HTYPE)
  - 2-3: 0x0800 (PTYPE)
  - 4: 0x06 (HLEN)
  - 5: 0x04 (PLEN)
  - 6-7: 0x0001 or 0x0002 (OPER)
  - 8-13: SHA
  - 14-17: SPA
  - 18-23: THA
  - 24-27: TPA
  - 28..PAD_LEN-1: 0x00
- Handshake:
  - Byte advances only when dout_valid && dout_ready.
  - With dout_ready low, dout, dout_valid and dout_last hold stable; no byte is dropped or repeated.
  - Full throughput: one byte per cycle with dout_ready tied high. No bubbles between bytes of a packet.
- Index counter: 8-bit, increments per handshake, saturates logically at PAD_LEN-1 (no wrap). SEND moves to PAD after the handshake of index 27 when PAD_LEN>28.
- dout_last=1 exactly while the index equals PAD_LEN-1 and dout_valid=1.
- Final handshake, next cycle: state=IDLE, dout_valid=0, busy=0, done=1.
  - start in that done cycle is accepted (back-to-back packets; minimum one idle cycle between packets).
- start while busy: ignored, with no effect on the in-flight packet or captured fields.
- Input changes after capture do not affect the in-flight packet.
- rst_n asserted mid-packet: immediate abort to reset values; no done pulse, no dout_last.

Decomposition:
- Shared package (arp_pkg): ARP_HTYPE_ETH=16'h0001, ARP_PTYPE_IPV4=16'h0800, ARP_HLEN=8'd6, ARP_PLEN=8'd4, ARP_OPER_REQ=16'd1, ARP_OPER_REP=16'd2, ARP_LEN=28, state enum typedef. The decoder uses the same constants.
- Single module. Field assembly and shift register are inline; no sub-module is warranted.

Test Plan:
- Reply, PAD_LEN=28, dout_ready=1:
  - Stimulus: our_mac=02:00:00:00:00:01, our_ip=192.168.1.10, tgt_mac=aa:bb:cc:dd:ee:ff, tgt_ip=192.168.1.1, oper_reply=1, pulse start.
  - Response: 28 consecutive bytes 00 01 08 00 06 04 00 02 02 00 00 00 00 01 c0 a8 01 0a aa bb cc dd ee ff c0 a8 01 01; dout_last on byte 27; done one cycle later.
- Request:
  - Stimulus: same fields, oper_reply=0.
  - Response: bytes 6-7 = 00 01; bytes 18-23 = 00×6 despite tgt_mac=aa:bb:…
- Backpressure:
  - Stimulus: dout_ready toggled pseudo-randomly (e.g. low 3 cycles at byte 10).
  - Response: dout/dout_valid stable while stalled; byte sequence identical to the first test; exactly 28 handshakes.
- PAD_LEN=46:
  - Response: bytes 28..45 = 0x00; dout_last only on byte 45; done after 46 handshakes.
- Start during busy, then back-to-back:
  - Stimulus: start at byte 5 of packet A (ignored); start in A's done cycle with new tgt_ip=10.0.0.7.
  - Response: A unchanged; packet B follows with bytes 24-27 = 0a 00 00 07.
- Reset mid-packet:
  - Stimulus: rst_n low at byte 15.
  - Response: dout_valid/busy drop asynchronously, no done; a subsequent start emits a full, correct packet from byte 0.
